// File: rtl/frame_window.sv
// Streaming window multiplier: rectangular passthrough or a mirrored half-size ROM window.
// Fixed 3-cycle latency, round half up, saturate to DATA_WIDTH. ROM image comes from COEF_INIT.
module frame_window #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned FRAME_LEN  = 4096,
    // Entry i of the half window sits in bits [i*COEF_WIDTH +: COEF_WIDTH]; default is flat 1.0
    parameter logic [FRAME_LEN/2*COEF_WIDTH-1:0] COEF_INIT =
        {(FRAME_LEN/2){1'b1, {(COEF_WIDTH-1){1'b0}}}}
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  mode_in,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic [DATA_WIDTH-1:0] in_sample,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic                  out_first,
    output logic                  out_last,
    output logic [15:0]           frame_count
);
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned ADDR_W    = IDX_W - 1;
    localparam int unsigned ROM_DEPTH = FRAME_LEN / 2;
    localparam int unsigned PROD_W    = DATA_WIDTH + COEF_WIDTH + 1;

    localparam logic [COEF_WIDTH-1:0]    UNITY   = COEF_WIDTH'(1) << (COEF_WIDTH - 1);
    localparam logic signed [PROD_W-1:0] RND     = PROD_W'(1) << (COEF_WIDTH - 2);
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         w_idx;
    logic                     r_mode;
    logic                     w_mode;

    logic                     r_p1_valid, r_p1_first, r_p1_last, r_p1_mode;
    logic [DATA_WIDTH-1:0]    r_p1_sample;
    logic [IDX_W-1:0]         r_p1_idx;

    logic                     r_p2_valid, r_p2_first, r_p2_last, r_p2_mode;
    logic [DATA_WIDTH-1:0]    r_p2_sample;
    logic [COEF_WIDTH-1:0]    r_rom_q;

    logic                     r_p3_valid, r_p3_first, r_p3_last;
    logic signed [PROD_W-1:0] r_p3_prod;

    logic                     r_out_valid, r_out_first, r_out_last;
    logic [DATA_WIDTH-1:0]    r_out_sample;
    logic [15:0]              r_frame_count;

    logic [COEF_WIDTH-1:0]    w_rom [ROM_DEPTH];
    logic [ADDR_W-1:0]        w_addr;
    logic [COEF_WIDTH-1:0]    w_coef;
    logic signed [PROD_W-1:0] w_mul_a, w_mul_b;
    logic signed [PROD_W-1:0] w_sum, w_shift;
    logic [DATA_WIDTH-1:0]    w_sat;

    // in_first restarts the frame; mode is captured only when a sample lands on index 0
    always_comb begin
        w_idx  = in_first ? '0 : r_idx;
        w_mode = (w_idx == '0) ? mode_in : r_mode;
    end

    always_comb begin
        for (int i = 0; i < ROM_DEPTH; i++) begin
            w_rom[i] = COEF_INIT[i*COEF_WIDTH +: COEF_WIDTH];
        end
    end

    // Second half of the frame reads the first half backwards: FRAME_LEN-1-idx == ~idx
    always_comb begin
        w_addr = r_p1_idx[IDX_W-1] ? ~r_p1_idx[ADDR_W-1:0] : r_p1_idx[ADDR_W-1:0];
    end

    always_comb begin
        w_coef  = r_p2_mode ? r_rom_q : UNITY;
        w_mul_a = PROD_W'($signed(r_p2_sample));
        w_mul_b = PROD_W'($signed({1'b0, w_coef}));
        w_sum   = r_p3_prod + RND;
        w_shift = w_sum >>> (COEF_WIDTH - 1);
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            w_sat = w_shift[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_idx       <= '0;
            r_mode      <= 1'b0;
            r_p1_valid  <= 1'b0;
            r_p1_first  <= 1'b0;
            r_p1_last   <= 1'b0;
            r_p1_mode   <= 1'b0;
            r_p1_sample <= '0;
            r_p1_idx    <= '0;
        end else begin
            if (in_valid) begin
                r_idx  <= w_idx + IDX_W'(1);
                r_mode <= w_mode;
            end
            r_p1_valid  <= in_valid;
            r_p1_first  <= in_valid && (w_idx == '0);
            r_p1_last   <= in_valid && (w_idx == IDX_W'(FRAME_LEN - 1));
            r_p1_mode   <= w_mode;
            r_p1_sample <= in_sample;
            r_p1_idx    <= w_idx;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_p2_valid  <= 1'b0;
            r_p2_first  <= 1'b0;
            r_p2_last   <= 1'b0;
            r_p2_mode   <= 1'b0;
            r_p2_sample <= '0;
            r_rom_q     <= '0;
            r_p3_valid  <= 1'b0;
            r_p3_first  <= 1'b0;
            r_p3_last   <= 1'b0;
            r_p3_prod   <= '0;
        end else begin
            r_p2_valid  <= r_p1_valid;
            r_p2_first  <= r_p1_first;
            r_p2_last   <= r_p1_last;
            r_p2_mode   <= r_p1_mode;
            r_p2_sample <= r_p1_sample;
            r_rom_q     <= w_rom[w_addr];
            r_p3_valid  <= r_p2_valid;
            r_p3_first  <= r_p2_first;
            r_p3_last   <= r_p2_last;
            r_p3_prod   <= w_mul_a * w_mul_b;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_out_valid   <= 1'b0;
            r_out_first   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_sample  <= '0;
            r_frame_count <= '0;
        end else begin
            r_out_valid  <= r_p3_valid;
            r_out_first  <= r_p3_first;
            r_out_last   <= r_p3_last;
            r_out_sample <= w_sat;
            if (r_out_valid && r_out_last) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_sample  = r_out_sample;
    assign out_first   = r_out_first;
    assign out_last    = r_out_last;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_frame_window.sv
// Scoreboard bench for frame_window: two instances share stimulus, one with the base ramp ROM
// and one with ROM[1]=0x4000 / ROM[2]=0xFFFF for rounding and saturation cases.
module tb_frame_window;
    localparam logic [127:0] ROM_A = {16'h7000, 16'h6000, 16'h5000, 16'h4000,
                                      16'h3000, 16'h2000, 16'h1000, 16'h0000};
    localparam logic [127:0] ROM_B = {16'h7000, 16'h6000, 16'h5000, 16'h4000,
                                      16'h3000, 16'hFFFF, 16'h4000, 16'h0000};

    typedef struct {
        int a;
        int b;
        int first;
        int last;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_in;
    logic mode_in, in_valid, in_first;
    logic signed [7:0] in_sample;
    logic out_valid, out_first, out_last;
    logic signed [7:0] out_sample;
    logic [15:0] frame_count;
    logic ovr_valid, ovr_first, ovr_last;
    logic signed [7:0] ovr_sample;
    logic [15:0] ovr_fc;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    exp_t q[$];
    exp_t m;

    // Expected outputs for an all-100 input frame, computed by hand
    int win_a [16] = '{0, 13, 25, 38, 50, 63, 75, 88, 88, 75, 63, 50, 38, 25, 13, 0};
    int win_b [16] = '{0, 50, 127, 38, 50, 63, 75, 88, 88, 75, 63, 50, 38, 127, 50, 0};
    int rv [16] = '{127, -128, 5, -1, 0, 1, 2, 3, -4, 64, -64, 100, -100, 7, -7, 55};

    frame_window #(
        .DATA_WIDTH(8), .COEF_WIDTH(16), .FRAME_LEN(16), .COEF_INIT(ROM_A)
    ) u_dut (
        .clk_in(clk), .rst_in(rst_in), .mode_in(mode_in), .in_valid(in_valid),
        .in_first(in_first), .in_sample(in_sample), .out_valid(out_valid),
        .out_sample(out_sample), .out_first(out_first), .out_last(out_last),
        .frame_count(frame_count)
    );

    frame_window #(
        .DATA_WIDTH(8), .COEF_WIDTH(16), .FRAME_LEN(16), .COEF_INIT(ROM_B)
    ) u_ovr (
        .clk_in(clk), .rst_in(rst_in), .mode_in(mode_in), .in_valid(in_valid),
        .in_first(in_first), .in_sample(in_sample), .out_valid(ovr_valid),
        .out_sample(ovr_sample), .out_first(ovr_first), .out_last(ovr_last),
        .frame_count(ovr_fc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic send(input logic v, input logic f, input logic md, input int s,
                        input int ea, input int eb, input int ef, input int el);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_first  = f;
        mode_in   = md;
        in_sample = 8'(s);
        @(posedge clk);
        #1;
        if (v) begin
            e.a = ea; e.b = eb; e.first = ef; e.last = el; e.due = cyc + 3;
            q.push_back(e);
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic check_fc(input string name, input int exp);
        repeat (5) @(negedge clk);
        check({name, "_a"}, int'(frame_count), exp);
        check({name, "_b"}, int'(ovr_fc), exp);
    endtask

    always @(negedge clk) begin
        if (out_valid || ovr_valid) begin
            check("valid_pair", int'(ovr_valid), int'(out_valid));
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got out_valid=1 sample %0d, expected none",
                         out_sample);
            end else begin
                m = q.pop_front();
                check("sample_a", int'(out_sample), m.a);
                check("sample_b", int'(ovr_sample), m.b);
                check("first", int'(out_first), m.first);
                check("last", int'(out_last), m.last);
                check("first_b", int'(ovr_first), m.first);
                check("last_b", int'(ovr_last), m.last);
                check("latency", cyc, m.due);
            end
        end
    end

    initial begin
        rst_in = 1'b1; mode_in = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_sample = '0;
        #12;
        check("rst_valid", int'(out_valid), 0);
        check("rst_sample", int'(out_sample), 0);
        check("rst_fc", int'(frame_count), 0);
        @(negedge clk);
        rst_in = 1'b0;

        // Rectangular passthrough, one full frame
        for (int i = 0; i < 16; i++) send(1, 0, 0, rv[i], rv[i], rv[i], i == 0, i == 15);
        check_fc("fc_rect", 1);

        // ROM window, mirrored
        for (int i = 0; i < 16; i++) send(1, 0, 1, 100, win_a[i], win_b[i], i == 0, i == 15);
        check_fc("fc_rom", 2);

        // Rounding/saturation, aborted partial frame, then mode toggle mid-frame
        send(1, 0, 1, 7, 0, 0, 1, 0);
        send(1, 0, 1, 3, 0, 2, 0, 0);
        send(1, 0, 1, 127, 32, 127, 0, 0);
        send(1, 1, 1, -5, 0, 0, 1, 0);
        send(1, 0, 1, -3, 0, -1, 0, 0);
        send(1, 0, 1, -128, -32, -128, 0, 0);
        for (int i = 3; i < 16; i++) send(1, 0, i < 5, 100, win_a[i], win_b[i], 0, i == 15);
        check_fc("fc_latch", 3);

        // Rectangular frame ignores a mid-frame mode change; then resync, gaps, resync at 9
        send(1, 0, 0, 100, 100, 100, 1, 0);
        send(1, 0, 1, 100, 100, 100, 0, 0);
        send(1, 1, 1, 100, 0, 0, 1, 0);
        send(1, 0, 1, 100, 13, 50, 0, 0);
        send(0, 1, 1, 99, 0, 0, 0, 0);
        send(1, 0, 1, 100, 25, 127, 0, 0);
        send(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 3; i < 9; i++) send(1, 0, 1, 100, win_a[i], win_b[i], 0, 0);
        send(1, 1, 1, 100, 0, 0, 1, 0);
        check_fc("fc_resync", 3);

        // Asynchronous reset with two samples still in flight
        send(1, 1, 0, 11, 11, 11, 1, 0);
        send(1, 0, 0, -22, -22, -22, 0, 0);
        send(1, 0, 0, 33, 33, 33, 0, 0);
        @(negedge clk);
        #1;
        rst_in = 1'b1;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_sample", int'(out_sample), 0);
        check("arst_first", int'(out_first), 0);
        check("arst_fc", int'(frame_count), 0);
        q.delete();
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        repeat (6) @(negedge clk);
        send(1, 0, 0, 42, 42, 42, 1, 0);
        check_fc("fc_post_rst", 0);
        check("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
